// File: rtl/crossbar_arbiter_if.sv
// Control-plane signals between the 2x2 crossbar
// masters, slaves and the ownership arbiter.
interface crossbar_arbiter_if;

    logic m0req;
    logic m1req;
    logic m0cmd;
    logic m1cmd;
    logic m0slv;
    logic m1slv;
    logic s0ack;
    logic s1ack;
    logic clr_tout;

    logic s0req;
    logic s1req;
    logic s0cmd;
    logic s1cmd;
    logic s0own;
    logic s1own;
    logic m0gnt;
    logic m1gnt;
    logic m0ack;
    logic m1ack;
    logic s0tout;
    logic s1tout;

    // Arbiter side: takes requests, drives grants.
    modport slave (
        input  m0req, m1req,
        input  m0cmd, m1cmd,
        input  m0slv, m1slv,
        input  s0ack, s1ack,
        input  clr_tout,
        output s0req, s1req,
        output s0cmd, s1cmd,
        output s0own, s1own,
        output m0gnt, m1gnt,
        output m0ack, m1ack,
        output s0tout, s1tout
    );

    // Requester side: drives requests, sees grants.
    modport master (
        output m0req, m1req,
        output m0cmd, m1cmd,
        output m0slv, m1slv,
        output s0ack, s1ack,
        output clr_tout,
        input  s0req, s1req,
        input  s0cmd, s1cmd,
        input  s0own, s1own,
        input  m0gnt, m1gnt,
        input  m0ack, m1ack,
        input  s0tout, s1tout
    );

endinterface

// File: rtl/crossbar_arbiter.sv
// Ownership arbiter for a 2x2 crossbar: one FSM and
// rotating-priority pointer per slave, plus ack routing.
module crossbar_arbiter #(
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    crossbar_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST =
        CW'(TIMEOUT - 1);

    logic [1:0] mreq;
    logic [1:0] mcmd;
    logic [1:0] mslv;
    logic [1:0] sack;

    logic [1:0] busy;
    logic [1:0] own;
    logic [1:0] tout;

    assign mreq = {bus.m1req, bus.m0req};
    assign mcmd = {bus.m1cmd, bus.m0cmd};
    assign mslv = {bus.m1slv, bus.m0slv};
    assign sack = {bus.s1ack, bus.s0ack};

    for (genvar j = 0; j < 2; j++) begin : g_slv

        localparam logic SJ = (j == 1);

        state_e        state_q;
        state_e        state_d;
        logic          own_q;
        logic          own_d;
        logic          prt_q;
        logic          prt_d;
        logic          tout_q;
        logic          tout_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        logic [1:0] cand;
        logic       hold;

        // Masters addressing this slave right now.
        assign cand = mreq & (SJ ? mslv : ~mslv);

        // Owner still wants this slave; else abort.
        assign hold = mreq[own_q]
                    & (mslv[own_q] == SJ);

        // Grant, completion, abort and timeout decisions.
        always_comb begin
            state_d = state_q;
            own_d   = own_q;
            prt_d   = prt_q;
            cnt_d   = cnt_q;
            tout_d  = tout_q & ~bus.clr_tout;
            unique case (state_q)
                IDLE: begin
                    if (cand != 2'b00) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        if (cand == 2'b11) begin
                            own_d = ROUND_ROBIN
                                  ? prt_q : 1'b0;
                        end else begin
                            own_d = cand[1];
                        end
                    end
                end
                BUSY: begin
                    if (sack[j]) begin
                        state_d = RELEASE;
                        if (ROUND_ROBIN) begin
                            prt_d = ~own_q;
                        end
                    end else if (!hold) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Dead slave: release it and
                        // pass priority on anyway.
                        state_d = RELEASE;
                        tout_d  = 1'b1;
                        if (ROUND_ROBIN) begin
                            prt_d = ~own_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Per-slave state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                own_q   <= 1'b0;
                prt_q   <= 1'b0;
                tout_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                own_q   <= own_d;
                prt_q   <= prt_d;
                tout_q  <= tout_d;
                cnt_q   <= cnt_d;
            end
        end

        assign busy[j] = (state_q == BUSY);
        assign own[j]  = own_q;
        assign tout[j] = tout_q;

    end

    assign bus.s0req = busy[0];
    assign bus.s1req = busy[1];

    // Command follows the owner live.
    assign bus.s0cmd = busy[0] & mcmd[own[0]];
    assign bus.s1cmd = busy[1] & mcmd[own[1]];

    assign bus.s0own = busy[0] & own[0];
    assign bus.s1own = busy[1] & own[1];

    assign bus.m0gnt = |(busy & ~own);
    assign bus.m1gnt = |(busy & own);

    // Acks only reach the master owning a busy slave.
    assign bus.m0ack = |(sack & busy & ~own);
    assign bus.m1ack = |(sack & busy & own);

    assign bus.s0tout = tout[0];
    assign bus.s1tout = tout[1];

endmodule
